// File: rtl/riscv_pipe_pkg.sv
// Shared types and constants for the RISC-V pipeline stage registers.
package riscv_pipe_pkg;

  localparam int unsigned DEF_XLEN    = 32;
  localparam int unsigned DEF_RADDR_W = 5;
  localparam int unsigned DEF_CTRL_W  = 4;

  localparam int unsigned CTRL_REGWRITE_BIT = 0;
  localparam int unsigned CTRL_MEMWRITE_BIT = 1;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

  typedef struct packed {
    logic [DEF_XLEN-1:0]    alu_result;
    logic [DEF_XLEN-1:0]    alu_result_f;
    logic [DEF_XLEN-1:0]    write_data;
    logic [DEF_RADDR_W-1:0] rd;
    logic [DEF_XLEN-1:0]    pc_plus4;
    logic [DEF_CTRL_W-1:0]  ctrl;
  } ex_mem_payload_t;

endpackage

// File: rtl/ex_mem_pipe_stage_skid_buf.sv
// Generic 2-entry skid buffer: head register drives the output, skid register
// absorbs the one beat accepted while the consumer stalls.
module pipe_skid_buf
  import riscv_pipe_pkg::*;
#(
  parameter type T = logic
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data,
  output logic out_valid_nxt_c,
  output T     out_data_nxt_c
);

  occ_t occ_q, occ_d;
  T     skid_q, skid_d, head_d;
  logic in_xfer, out_xfer, in_ready_d;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) occ_q <= OCC_EMPTY;
    else       occ_q <= occ_d;
  end

  // Next occupancy; flush overrides every transfer
  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = OCC_EMPTY;
    end else begin
      case (occ_q)
        OCC_EMPTY: if (in_xfer) occ_d = OCC_ONE;
        OCC_ONE: begin
          if (in_xfer && !out_xfer)      occ_d = OCC_TWO;
          else if (!in_xfer && out_xfer) occ_d = OCC_EMPTY;
        end
        OCC_TWO:   if (out_xfer) occ_d = OCC_ONE;
        default:   occ_d = OCC_EMPTY;
      endcase
    end
  end

  // Datapath steering and next-cycle handshake outputs
  always_comb begin
    head_d = out_data;
    skid_d = skid_q;
    if (!flush) begin
      case (occ_q)
        OCC_EMPTY: if (in_xfer) head_d = in_data;
        OCC_ONE: begin
          if (in_xfer && out_xfer) head_d = in_data;
          else if (in_xfer)        skid_d = in_data;
        end
        OCC_TWO:   if (out_xfer) head_d = skid_q;
        default:   head_d = out_data;
      endcase
    end
    out_valid_nxt_c = (occ_d != OCC_EMPTY);
    in_ready_d      = (occ_d != OCC_TWO);
    out_data_nxt_c  = head_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data  <= '0;
      skid_q    <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      out_data  <= head_d;
      skid_q    <= skid_d;
      out_valid <= out_valid_nxt_c;
      in_ready  <= in_ready_d;
    end
  end

endmodule

// File: rtl/ex_mem_pipe_stage.sv
// Elastic EX->MEM pipeline register with skid buffering, flush and
// x0-qualified forwarding taps for the hazard unit.
module ex_mem_pipe_stage
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned XLEN    = DEF_XLEN,
  parameter int unsigned RADDR_W = DEF_RADDR_W,
  parameter int unsigned CTRL_W  = DEF_CTRL_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    alu_result_e,
  input  logic [XLEN-1:0]    alu_result_f_e,
  input  logic [XLEN-1:0]    write_data_e,
  input  logic [RADDR_W-1:0] rd_e,
  input  logic [XLEN-1:0]    pc_plus4_e,
  input  logic [CTRL_W-1:0]  ctrl_e,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    alu_result_m,
  output logic [XLEN-1:0]    alu_result_f_m,
  output logic [XLEN-1:0]    write_data_m,
  output logic [RADDR_W-1:0] rd_m,
  output logic [XLEN-1:0]    pc_plus4_m,
  output logic [CTRL_W-1:0]  ctrl_m,
  output logic               fwd_reg_write,
  output logic [RADDR_W-1:0] fwd_rd
);

  typedef struct packed {
    logic [XLEN-1:0]    alu_result;
    logic [XLEN-1:0]    alu_result_f;
    logic [XLEN-1:0]    write_data;
    logic [RADDR_W-1:0] rd;
    logic [XLEN-1:0]    pc_plus4;
    logic [CTRL_W-1:0]  ctrl;
  } payload_t;

  payload_t in_pl, head_pl, head_nxt_pl;
  logic     out_valid_nxt, fwd_we_d;

  always_comb begin
    in_pl              = '0;
    in_pl.alu_result   = alu_result_e;
    in_pl.alu_result_f = alu_result_f_e;
    in_pl.write_data   = write_data_e;
    in_pl.rd           = rd_e;
    in_pl.pc_plus4     = pc_plus4_e;
    in_pl.ctrl         = ctrl_e;
  end

  pipe_skid_buf #(.T(payload_t)) u_skid (
    .clk             (clk),
    .reset           (reset),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_pl),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (head_pl),
    .out_valid_nxt_c (out_valid_nxt),
    .out_data_nxt_c  (head_nxt_pl)
  );

  assign alu_result_m   = head_pl.alu_result;
  assign alu_result_f_m = head_pl.alu_result_f;
  assign write_data_m   = head_pl.write_data;
  assign rd_m           = head_pl.rd;
  assign pc_plus4_m     = head_pl.pc_plus4;
  assign ctrl_m         = head_pl.ctrl;

  // Forwarding taps computed from next head state so they stay registered
  assign fwd_we_d = out_valid_nxt & head_nxt_pl.ctrl[CTRL_REGWRITE_BIT]
                  & (head_nxt_pl.rd != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_reg_write <= 1'b0;
      fwd_rd        <= '0;
    end else begin
      fwd_reg_write <= fwd_we_d;
      fwd_rd        <= fwd_we_d ? head_nxt_pl.rd : '0;
    end
  end

endmodule
